avl_frame_writer: RTL
=====================

Name: avl_frame_writer

Overview:
- Upstream write master for sdram_controller: packs the camera pixel stream (RGB565, 16 bit) into 32-bit words and buffers them in an internal FIFO.
- Issues fixed-length Avalon burst writes into the SDRAM frame buffer through the controller's avl_s0 slave.
- At each frame boundary, flushes the partial tail and rewinds the write address to FRAME_BASE.
- Sits between the OV5640 capture logic and sdram_controller.

Parameters:
- FRAME_BASE, 32'h0000_0000, byte address of the frame buffer start.
- BURST_LEN, 64, words per full burst (1..255).
- FIFO_DEPTH, 512, word FIFO depth; power of two, at least 2*BURST_LEN.

Ports:
- clk  in  1  system clock.
- rest_n  in  1  synchronous active-low reset.
- enable  in  1  accept pixels when 1.
- pix_valid  in  1  pix_data valid this cycle.
- pix_data  in  16  RGB565 pixel.
- frame_sync  in  1  one-cycle pulse between frames (vsync edge).
- avl_address  out  32  byte address of the burst.
- avl_byte_en  out  4  byte enables.
- avl_write  out  1  write request.
- avl_read  out  1  read request, tied 0.
- avl_write_data  out  32  write beat data.
- avl_begin_burst_transfer  out  1  first-beat marker.
- avl_burst_count  out  8  beats in burst.
- avl_resp_ready  out  1  tied 0 (write-only master).
- avl_wait_request  in  1  slave stall.
- frame_done  out  1  one-cycle pulse when a frame is fully flushed.
- overflow  out  1  sticky: a pixel was dropped.

Behaviour:
- Reset: all outputs 0; address register = FRAME_BASE; FIFO empty; pack register empty; state IDLE.
- Packing:
  - First accepted pixel of a pair goes to bits [15:0], the second to bits [31:16].
  - The word is pushed into the FIFO on the cycle the second pixel is accepted.
  - A pixel is accepted when pix_valid && enable && !flush_pending && FIFO not full.
  - pix_valid && enable while the FIFO is full or flush_pending: drop the pixel and set overflow.
  - overflow clears only on reset.
- FIFO: first-word-fall-through. The engine is its only reader.
- States:
  - IDLE: if fifo_level >= BURST_LEN, latch N = BURST_LEN. Else if flush_pending && fifo_level > 0, latch N = fifo_level. Either way, go to WRITE on the next cycle. If flush_pending && fifo_level == 0, go to DONE.
  - WRITE:
    - avl_write = 1, avl_write_data = FIFO head, avl_byte_en = 4'hF.
    - avl_address = address register, held for the whole burst.
    - avl_burst_count = N, held for the whole burst.
    - avl_begin_burst_transfer = 1 on the first beat only, until that beat is accepted.
    - A beat is accepted when avl_write && !avl_wait_request; pop the FIFO and decrement the beat counter.
    - While stalled, all outputs hold stable.
    - When the last beat is accepted: address += 4*N, avl_write drops the next cycle, return to IDLE.
    - No bubbles: N words are present at burst start.
  - DONE: address register = FRAME_BASE; frame_done = 1 for exactly one cycle; flush_pending cleared; return to IDLE.
- frame_sync:
  - Sets flush_pending.
  - If the pack register holds an odd pixel, that same cycle push {16'h0, pixel}. If the FIFO is full at that moment, drop it and set overflow.
  - frame_sync arriving during WRITE does not disturb the current burst; the flush follows.
  - frame_sync while flush_pending is already set has no further effect.
- enable low: stop accepting pixels. An in-flight burst completes and queued words still drain.
- Simultaneous push and pop in one cycle: fifo_level unchanged.
- Reset asserted mid-burst: all outputs 0 on the next edge. The partial burst is abandoned; the slave must tolerate this.

Test Plan:
- BURST_LEN=4 build; enable=1; pixels 0x0001..0x0008 on consecutive cycles, wait_request=0 -> one burst at address 0x0, burst_count=4. Data is 0x00020001, 0x00040003, 0x00060005, 0x00080007. begin_burst_transfer is high on beat 1 only.
- Same stimulus, then 8 more pixels -> second burst at address 0x10. Then frame_sync -> frame_done pulses once; the next burst starts at 0x0.
- 3 pixels (0x0001..0x0003) then frame_sync -> burst_count=2, data 0x00020001 then 0x00000003. Then frame_done; overflow stays 0.
- wait_request high for 5 cycles on beat 1 and on beat 3 -> address, data, burst_count and begin stay stable while stalled. Exactly 4 accepted beats, FIFO popped 4 times.
- wait_request held high, 2*FIFO_DEPTH+10 pixels -> overflow=1. After release, the first FIFO_DEPTH words are written in order with no duplicates.
- rest_n low for 1 cycle mid-burst -> avl_write, begin and frame_done are 0 next cycle. Address returns to FRAME_BASE and a subsequent burst is correct.

Source files
------------

// File: rtl/avl_frame_writer.sv
// Packs a 16-bit pixel stream into 32-bit words, queues them in a FWFT FIFO and
// writes them to SDRAM as fixed-length Avalon bursts, rewinding at each frame.
module avl_frame_writer #(
    parameter logic [31:0] FRAME_BASE = 32'h0000_0000,
    parameter int          BURST_LEN  = 64,
    parameter int          FIFO_DEPTH = 512
) (
    input  logic        clk,
    input  logic        rest_n,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        frame_sync,
    output logic [31:0] avl_address,
    output logic [3:0]  avl_byte_en,
    output logic        avl_write,
    output logic        avl_read,
    output logic [31:0] avl_write_data,
    output logic        avl_begin_burst_transfer,
    output logic [7:0]  avl_burst_count,
    output logic        avl_resp_ready,
    input  logic        avl_wait_request,
    output logic        frame_done,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [31:0]   fifo_head;
    logic          fifo_full;

    logic [15:0]   pack_data_reg, pack_data_next;
    logic          pack_valid_reg, pack_valid_next;
    logic          flush_pending_reg;
    logic          overflow_reg;

    logic [31:0]   addr_reg;
    logic [7:0]    burst_n_reg;
    logic [7:0]    beats_left_reg;
    logic          first_beat_reg;

    logic          pix_req, pix_accept, pix_drop, sync_start;
    logic          push_req, push_do, tail_drop;
    logic [31:0]   push_word;
    logic          pop, last_beat;
    logic          load_burst;
    logic [7:0]    burst_n_next;

    assign fifo_full  = (level_reg == LW'(FIFO_DEPTH));
    assign fifo_head  = fifo_mem[rd_ptr_reg];

    assign pix_req    = enable && pix_valid;
    assign pix_accept = pix_req && !flush_pending_reg && !fifo_full;
    assign pix_drop   = pix_req && !pix_accept;
    assign sync_start = frame_sync && !flush_pending_reg;

    // The pixel of this cycle is packed first; a frame_sync in the same cycle
    // then flushes whatever half-word remains, so at most one push per cycle.
    always_comb begin
        push_req        = 1'b0;
        push_word       = 32'h0;
        pack_valid_next = pack_valid_reg;
        pack_data_next  = pack_data_reg;
        if (pix_accept) begin
            if (pack_valid_reg) begin
                push_req        = 1'b1;
                push_word       = {pix_data, pack_data_reg};
                pack_valid_next = 1'b0;
            end else begin
                pack_valid_next = 1'b1;
                pack_data_next  = pix_data;
            end
        end
        if (sync_start && pack_valid_next && !push_req) begin
            push_req        = 1'b1;
            push_word       = {16'h0000, pack_data_next};
            pack_valid_next = 1'b0;
        end
    end

    assign push_do   = push_req && !fifo_full;
    assign tail_drop = push_req && fifo_full;

    assign pop       = (state_reg == WRITE) && !avl_wait_request;
    assign last_beat = pop && (beats_left_reg == 8'd1);

    always_comb begin
        state_next   = state_reg;
        load_burst   = 1'b0;
        burst_n_next = 8'(BURST_LEN);
        case (state_reg)
            IDLE: begin
                if (level_reg >= LW'(BURST_LEN)) begin
                    load_burst = 1'b1;
                    state_next = WRITE;
                end else if (flush_pending_reg && (level_reg != '0)) begin
                    load_burst   = 1'b1;
                    burst_n_next = 8'(level_reg);
                    state_next   = WRITE;
                end else if (flush_pending_reg) begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                if (last_beat) begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rest_n) begin
            state_reg         <= IDLE;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            level_reg         <= '0;
            pack_data_reg     <= 16'h0;
            pack_valid_reg    <= 1'b0;
            flush_pending_reg <= 1'b0;
            overflow_reg      <= 1'b0;
            addr_reg          <= FRAME_BASE;
            burst_n_reg       <= 8'h0;
            beats_left_reg    <= 8'h0;
            first_beat_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pack_data_reg  <= pack_data_next;
            pack_valid_reg <= pack_valid_next;

            if (pix_drop || tail_drop) begin
                overflow_reg <= 1'b1;
            end

            if (state_reg == DONE) begin
                flush_pending_reg <= 1'b0;
            end else if (frame_sync) begin
                flush_pending_reg <= 1'b1;
            end

            if (push_do) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_do, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase

            if (load_burst) begin
                burst_n_reg    <= burst_n_next;
                beats_left_reg <= burst_n_next;
                first_beat_reg <= 1'b1;
            end else if (pop) begin
                beats_left_reg <= beats_left_reg - 1'b1;
                first_beat_reg <= 1'b0;
            end

            if (state_reg == DONE) begin
                addr_reg <= FRAME_BASE;
            end else if (last_beat) begin
                addr_reg <= addr_reg + {22'h0, burst_n_reg, 2'b00};
            end
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push_do) begin
            fifo_mem[wr_ptr_reg] <= push_word;
        end
    end

    assign avl_write                = (state_reg == WRITE);
    assign avl_address              = avl_write ? addr_reg : 32'h0;
    assign avl_byte_en              = avl_write ? 4'hF : 4'h0;
    assign avl_write_data           = avl_write ? fifo_head : 32'h0;
    assign avl_burst_count          = avl_write ? burst_n_reg : 8'h0;
    assign avl_begin_burst_transfer = avl_write && first_beat_reg;
    assign avl_read                 = 1'b0;
    assign avl_resp_ready           = 1'b0;
    assign frame_done               = (state_reg == DONE);
    assign overflow                 = overflow_reg;

endmodule
